// File: rtl/avr_pin_change_port_if.sv
// Pin-change port bundle: core-side control/status plus the raw external pins.
// The core drives the controls (master); the port drives the results back (slave).
interface avr_pin_change_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] pc_mask;
  logic [1:0]       edge_sel;
  logic             irq_en;
  logic             flag_clr;
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] pc_bits;
  logic             pc_flag;
  logic             pc_irq;

  modport master (
    output pin_in,
    output pc_mask,
    output edge_sel,
    output irq_en,
    output flag_clr,
    input  pin_val,
    input  pc_bits,
    input  pc_flag,
    input  pc_irq
  );

  modport slave (
    input  pin_in,
    input  pc_mask,
    input  edge_sel,
    input  irq_en,
    input  flag_clr,
    output pin_val,
    output pc_bits,
    output pc_flag,
    output pc_irq
  );
endinterface

// File: rtl/avr_pin_change_port.sv
// Synchronised AVR input port (PINx) with maskable per-bit edge capture
// and a single registered interrupt request.
module avr_pin_change_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  avr_pin_change_port_if.slave  bus
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("avr_pin_change_port: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("avr_pin_change_port: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pc_bits_q, pc_bits_d;
  logic             pc_flag_q, pc_flag_d;
  logic             pc_irq_q,  pc_irq_d;
  logic [CNT_W-1:0] settle_q,  settle_d;

  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] raw_evt;
  logic [WIDTH-1:0] qual_evt;
  edge_mode_e       edge_mode;

  assign pin_val   = sync_q[SYNC_STAGES-1];
  assign edge_mode = edge_mode_e'(bus.edge_sel);

  always_comb begin
    raw_evt = '0;
    unique case (edge_mode)
      EDGE_ANY:  raw_evt = pin_val ^ prev_q;
      EDGE_RISE: raw_evt = pin_val & ~prev_q;
      EDGE_FALL: raw_evt = ~pin_val & prev_q;
      EDGE_OFF:  raw_evt = '0;
      default:   raw_evt = '0;
    endcase
  end

  // Events are ignored until the chain has flushed the all-zero reset state.
  always_comb begin
    qual_evt = '0;
    if (settle_q == '0) begin
      qual_evt = raw_evt & bus.pc_mask;
    end
  end

  // Set beats clear: a same-cycle event survives flag_clr.
  always_comb begin
    pc_bits_d = (bus.flag_clr ? '0 : pc_bits_q) | qual_evt;
    pc_flag_d = (bus.flag_clr ? 1'b0 : pc_flag_q) | (|qual_evt);
    pc_irq_d  = pc_flag_d & bus.irq_en;
    settle_d  = (settle_q == '0) ? '0 : settle_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      pc_bits_q <= '0;
      pc_flag_q <= 1'b0;
      pc_irq_q  <= 1'b0;
      settle_q  <= SETTLE_LOAD;
    end else begin
      sync_q[0] <= bus.pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q    <= pin_val;
      pc_bits_q <= pc_bits_d;
      pc_flag_q <= pc_flag_d;
      pc_irq_q  <= pc_irq_d;
      settle_q  <= settle_d;
    end
  end

  assign bus.pin_val = pin_val;
  assign bus.pc_bits = pc_bits_q;
  assign bus.pc_flag = pc_flag_q;
  assign bus.pc_irq  = pc_irq_q;

endmodule

// File: tb/tb_avr_pin_change_port.sv
// Directed bench for avr_pin_change_port: a sample-history model checked every
// cycle, plus literal expectations at the points the behaviour is pinned down.
module tb_avr_pin_change_port;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avr_pin_change_port_if #(.WIDTH(W)) bus ();

  avr_pin_change_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: hist[k] is the pin_in sample taken k+1 edges ago (zeros after reset).
  // PINx is the sample from S edges ago; the "previous" PINx is from S+1 ago.
  logic [W-1:0] hist [0:S];
  int           age;
  logic [W-1:0] m_bits;
  logic         m_flag;
  logic         m_irq;
  logic [W-1:0] m_pin_val;
  assign m_pin_val = hist[S-1];

  function automatic logic [W-1:0] model_events();
    logic [W-1:0] cur, old, raw;
    cur = hist[S-1];
    old = hist[S];
    case (bus.edge_sel)
      2'b00:   raw = cur ^ old;
      2'b01:   raw = cur & ~old;
      2'b10:   raw = ~cur & old;
      default: raw = '0;
    endcase
    if (age < S + 1) return '0;
    return raw & bus.pc_mask;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= S; i++) hist[i] <= '0;
      age    <= 0;
      m_bits <= '0;
      m_flag <= 1'b0;
      m_irq  <= 1'b0;
    end else begin
      for (int i = S; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= bus.pin_in;
      if (age < 1000) age <= age + 1;
      m_bits <= (bus.flag_clr ? '0 : m_bits) | model_events();
      m_flag <= (bus.flag_clr ? 1'b0 : m_flag) | (|model_events());
      m_irq  <= ((bus.flag_clr ? 1'b0 : m_flag) | (|model_events())) & bus.irq_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model pin_val", 32'(bus.pin_val), 32'(m_pin_val));
    check("model pc_bits", 32'(bus.pc_bits), 32'(m_bits));
    check("model pc_flag", 32'(bus.pc_flag), 32'(m_flag));
    check("model pc_irq",  32'(bus.pc_irq),  32'(m_irq));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_flags();
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
  endtask

  initial begin
    bus.pin_in   = 8'hFF;
    bus.pc_mask  = 8'h00;
    bus.edge_sel = 2'b00;
    bus.irq_en   = 1'b0;
    bus.flag_clr = 1'b0;

    // Reset with pins held high: no events after release.
    @(negedge clk);
    rst = 1'b1;
    ticks(3);
    check("reset pin_val", 32'(bus.pin_val), 32'h00);
    check("reset pc_flag", 32'(bus.pc_flag), 32'h0);
    bus.pc_mask = 8'hFF;
    rst = 1'b0;
    tick();
    tick();
    check("settle pin_val", 32'(bus.pin_val), 32'hFF);
    ticks(4);
    check("settle pc_bits", 32'(bus.pc_bits), 32'h00);
    check("settle pc_flag", 32'(bus.pc_flag), 32'h0);

    // Latency from pin edge to PINx and flag.
    bus.pc_mask = 8'h00;
    bus.pin_in  = 8'hFE;
    ticks(4);
    bus.pc_mask = 8'h01;
    bus.irq_en  = 1'b1;
    bus.pin_in  = 8'hFF;
    tick();
    check("lat pin_val k", 32'(bus.pin_val), 32'hFE);
    tick();
    check("lat pin_val k+1", 32'(bus.pin_val), 32'hFF);
    check("lat flag k+1", 32'(bus.pc_flag), 32'h0);
    tick();
    check("lat pc_bits", 32'(bus.pc_bits), 32'h01);
    check("lat pc_flag", 32'(bus.pc_flag), 32'h1);
    check("lat pc_irq", 32'(bus.pc_irq), 32'h1);

    // Rising-only on bit 3.
    bus.pc_mask = 8'h00;
    bus.pin_in  = 8'hF7;
    ticks(4);
    clear_flags();
    bus.pc_mask  = 8'h08;
    bus.edge_sel = 2'b01;
    bus.pin_in   = 8'hFF;
    ticks(3);
    check("rise sets", 32'(bus.pc_bits), 32'h08);
    clear_flags();
    bus.pin_in = 8'hF7;
    ticks(4);
    check("rise ignores fall", 32'(bus.pc_bits), 32'h00);

    // Falling-only.
    bus.edge_sel = 2'b10;
    bus.pin_in   = 8'hFF;
    ticks(4);
    check("fall ignores rise", 32'(bus.pc_bits), 32'h00);
    bus.pin_in = 8'hF7;
    ticks(4);
    check("fall sets", 32'(bus.pc_bits), 32'h08);
    clear_flags();

    // Detection off.
    bus.edge_sel = 2'b11;
    bus.pin_in   = 8'hFF;
    ticks(4);
    bus.pin_in = 8'hF7;
    ticks(4);
    check("off bits", 32'(bus.pc_bits), 32'h00);
    check("off flag", 32'(bus.pc_flag), 32'h0);

    // Masking.
    bus.edge_sel = 2'b00;
    bus.pc_mask  = 8'h00;
    bus.pin_in   = 8'h00;
    ticks(4);
    clear_flags();
    bus.pc_mask = 8'h0F;
    bus.pin_in  = 8'hF0;
    ticks(4);
    check("mask hides bits", 32'(bus.pc_bits), 32'h00);
    check("mask hides flag", 32'(bus.pc_flag), 32'h0);
    bus.pin_in = 8'hF2;
    ticks(4);
    check("mask passes bit1", 32'(bus.pc_bits), 32'h02);
    clear_flags();

    // Set beats clear.
    bus.pc_mask = 8'h05;
    bus.pin_in  = 8'hF3;
    ticks(4);
    check("sbc pre bits", 32'(bus.pc_bits), 32'h01);
    bus.pin_in = 8'hF7;
    tick();
    tick();
    bus.flag_clr = 1'b1;
    tick();
    bus.flag_clr = 1'b0;
    check("sbc bits", 32'(bus.pc_bits), 32'h04);
    check("sbc flag", 32'(bus.pc_flag), 32'h1);
    bus.pc_mask = 8'h00;
    tick();
    check("unmask keeps bits", 32'(bus.pc_bits), 32'h04);

    // irq_en gating.
    bus.irq_en = 1'b0;
    clear_flags();
    bus.pc_mask = 8'h04;
    bus.pin_in  = 8'hF3;
    ticks(4);
    check("gate flag", 32'(bus.pc_flag), 32'h1);
    check("gate irq off", 32'(bus.pc_irq), 32'h0);
    bus.irq_en = 1'b1;
    tick();
    check("gate irq on", 32'(bus.pc_irq), 32'h1);
    clear_flags();
    check("clr flag", 32'(bus.pc_flag), 32'h0);
    check("clr irq", 32'(bus.pc_irq), 32'h0);

    // Reset mid-operation drops the flag and restarts the settle window.
    bus.pc_mask = 8'hFF;
    bus.pin_in  = 8'h00;
    ticks(4);
    check("pre-rst flag", 32'(bus.pc_flag), 32'h1);
    rst = 1'b1;
    tick();
    check("mid-rst flag", 32'(bus.pc_flag), 32'h0);
    check("mid-rst bits", 32'(bus.pc_bits), 32'h00);
    rst = 1'b0;
    bus.pin_in = 8'hFF;
    ticks(6);
    check("post-rst flag", 32'(bus.pc_flag), 32'h0);

    // Mixed traffic, model-checked every cycle.
    for (int i = 0; i < 300; i++) begin
      bus.pin_in   = W'($urandom);
      bus.pc_mask  = W'($urandom);
      bus.edge_sel = 2'($urandom_range(0, 3));
      bus.irq_en   = ($urandom_range(0, 3) != 0);
      bus.flag_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.flag_clr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
